// File: rtl/uart_seq_player.sv
// Byte-sequence player: replays a loadable byte table into a uart_tx byte port with gap/loop/abort/timeout.
// Latency: start -> first tx_data_vld_o = 2 cycles; byte-to-byte = tx time + gap_i + 2 cycles (gap_i >= 1).
// Backpressure: holds tx_data_vld_o until tx_data_rdy_i drops (accept); gives up after TMO_CYCLES with tmo_err_o.
module uart_seq_player #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int GAP_WIDTH  = 16,
    parameter int TMO_CYCLES = 4096,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  tbl_wr_en_i,
    input  logic [AW-1:0]         tbl_wr_addr_i,
    input  logic [DATA_WIDTH-1:0] tbl_wr_data_i,
    input  logic [AW:0]           len_i,
    input  logic [GAP_WIDTH-1:0]  gap_i,
    input  logic [15:0]           pass_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  tx_data_rdy_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_data_vld_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  abort_o,
    output logic                  tmo_err_o,
    output logic [AW-1:0]         byte_idx_o,
    output logic [15:0]           pass_cnt_o
);

    localparam int          TW       = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
    localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_WAIT_TX,
        S_GAP,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   tbl_mem [DEPTH];
    logic [AW:0]             len_q;
    logic [GAP_WIDTH-1:0]    gap_q;
    logic [GAP_WIDTH-1:0]    gap_cnt_q;
    logic [15:0]             pass_q;
    logic [15:0]             pass_cnt_q;
    logic [AW-1:0]           idx_q;
    logic [TW-1:0]           tmo_cnt_q;
    logic                    stop_pend_q;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic                    vld_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    abort_q;
    logic                    tmo_err_q;

    logic                    last_byte;
    logic                    stop_req;
    logic [15:0]             pass_cnt_d;
    logic                    pass_done;
    logic [AW:0]             len_d;

    // Table storage: plain write port, not reset; contents are only meaningful once loaded.
    always_ff @(posedge clk_i) begin
        if (tbl_wr_en_i) begin
            tbl_mem[tbl_wr_addr_i] <= tbl_wr_data_i;
        end
    end

    // Pass bookkeeping and start-time length clamp (lengths above DEPTH would never hit the last index).
    always_comb begin
        last_byte  = ({1'b0, idx_q} == (len_q - (AW + 1)'(1)));
        stop_req   = stop_i | stop_pend_q;
        pass_cnt_d = (pass_cnt_q == 16'hFFFF) ? pass_cnt_q : pass_cnt_q + 16'd1;
        pass_done  = (pass_q != 16'd0) && (pass_cnt_d == pass_q);
        len_d      = (len_i > DEPTH_L) ? DEPTH_L : len_i;
    end

    // Playback FSM; every output is a register updated here.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            pass_q      <= '0;
            pass_cnt_q  <= '0;
            idx_q       <= '0;
            tmo_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            tx_data_q   <= '0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    // A simultaneous stop suppresses the start entirely.
                    if (start_i && !stop_i) begin
                        len_q       <= len_d;
                        gap_q       <= gap_i;
                        pass_q      <= pass_i;
                        pass_cnt_q  <= '0;
                        tmo_err_q   <= 1'b0;
                        abort_q     <= 1'b0;
                        idx_q       <= '0;
                        stop_pend_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= (len_d == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (stop_i) begin
                        abort_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        // Read happens here so late table writes are still picked up.
                        tx_data_q <= tbl_mem[idx_q];
                        vld_q     <= 1'b1;
                        tmo_cnt_q <= '0;
                        state_q   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!tx_data_rdy_i) begin
                        // Accepted: the byte is now on the line, so a stop must wait for it.
                        vld_q   <= 1'b0;
                        state_q <= S_WAIT_TX;
                        if (stop_i) begin
                            stop_pend_q <= 1'b1;
                        end
                    end else if (stop_i) begin
                        vld_q   <= 1'b0;
                        abort_q <= 1'b1;
                        state_q <= S_DONE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        vld_q     <= 1'b0;
                        tmo_err_q <= 1'b1;
                        abort_q   <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                S_WAIT_TX: begin
                    if (tx_data_rdy_i) begin
                        if (stop_req) begin
                            abort_q <= 1'b1;
                            state_q <= S_DONE;
                        end else if (gap_q > GAP_WIDTH'(1)) begin
                            // The cycle rdy is seen high is already the first idle cycle.
                            gap_cnt_q <= gap_q - GAP_WIDTH'(1);
                            state_q   <= S_GAP;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end else if (stop_i) begin
                        stop_pend_q <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (stop_i) begin
                        abort_q <= 1'b1;
                        state_q <= S_DONE;
                    end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
                        state_q <= S_NEXT;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
                    end
                end
                S_NEXT: begin
                    if (stop_i) begin
                        abort_q <= 1'b1;
                        state_q <= S_DONE;
                    end else if (last_byte) begin
                        pass_cnt_q <= pass_cnt_d;
                        idx_q      <= '0;
                        state_q    <= pass_done ? S_DONE : S_READ;
                    end else begin
                        idx_q   <= idx_q + AW'(1);
                        state_q <= S_READ;
                    end
                end
                S_DONE: begin
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    vld_q       <= 1'b0;
                    stop_pend_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_data_o     = tx_data_q;
    assign tx_data_vld_o = vld_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign abort_o       = abort_q;
    assign tmo_err_o     = tmo_err_q;
    assign byte_idx_o    = idx_q;
    assign pass_cnt_o    = pass_cnt_q;

endmodule

// File: tb/tb_uart_seq_player.sv
// Directed bench for uart_seq_player with a uart_tx responder and a byte scoreboard.
// Cycle numbers below are values of cyc seen 1 time unit after a rising edge.
// The responder accepts a byte by dropping rdy in the first cycle vld is seen.
module tb_uart_seq_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tbl_wr_en = 1'b0;
    logic [5:0]  tbl_wr_addr = '0;
    logic [7:0]  tbl_wr_data = '0;
    logic [6:0]  len = '0;
    logic [15:0] gap = '0;
    logic [15:0] pass = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        rdy;
    logic [7:0]  tx_data;
    logic        vld;
    logic        busy;
    logic        done;
    logic        abort;
    logic        tmo_err;
    logic [5:0]  byte_idx;
    logic [15:0] pass_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int vld_hi_cnt = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    // responder state
    int  tx_busy = 10;
    bit  tx_hold = 1'b0;
    int  acc_cnt = 0;
    int  acc_cyc [256];
    int  rise_cyc [256];
    logic [7:0] exp_q [$];

    logic [7:0] t1 [14];

    uart_seq_player #(
        .DATA_WIDTH(8),
        .DEPTH(64),
        .GAP_WIDTH(16),
        .TMO_CYCLES(16)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .tbl_wr_en_i(tbl_wr_en),
        .tbl_wr_addr_i(tbl_wr_addr),
        .tbl_wr_data_i(tbl_wr_data),
        .len_i(len),
        .gap_i(gap),
        .pass_i(pass),
        .start_i(start),
        .stop_i(stop),
        .tx_data_rdy_i(rdy),
        .tx_data_o(tx_data),
        .tx_data_vld_o(vld),
        .busy_o(busy),
        .done_o(done),
        .abort_o(abort),
        .tmo_err_o(tmo_err),
        .byte_idx_o(byte_idx),
        .pass_cnt_o(pass_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Activity counters sampled mid-cycle.
    always @(negedge clk) begin
        if (vld)  vld_hi_cnt <= vld_hi_cnt + 1;
        if (done) done_cnt   <= done_cnt + 1;
        if (busy) busy_cnt   <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // uart_tx stand-in: drops rdy on accept, holds it low for tx_busy cycles.
    initial begin
        rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (vld && rdy && !tx_hold && rst_n) begin
                rdy = 1'b0;
                acc_cyc[acc_cnt & 255] = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                end
                acc_cnt++;
                repeat (tx_busy) @(posedge clk);
                #1;
                rdy = 1'b1;
                rise_cyc[(acc_cnt - 1) & 255] = cyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input int a, input logic [7:0] d);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = a[5:0];
        tbl_wr_data = d;
        step(1);
        tbl_wr_en   = 1'b0;
    endtask

    task automatic do_start(input int l, input int g, input int p);
        len   = l[6:0];
        gap   = g[15:0];
        pass  = p[15:0];
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            step(1);
            n++;
        end
        check(tag, {31'h0, done}, 32'h1);
    endtask

    task automatic wait_vld(input int budget, input string tag);
        int n = 0;
        while (!vld && n < budget) begin
            step(1);
            n++;
        end
        check(tag, {31'h0, vld}, 32'h1);
    endtask

    initial begin
        int t0, base, d0, v0, b0, acc0, r0;
        t1 = '{8'h2a, 8'h2c, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0b,
               8'h00, 8'h00, 8'h00, 8'h2e, 8'h93, 8'h05, 8'h2b};

        // ---- reset state ----
        step(3);
        check("rst_vld",  {31'h0, vld}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_tmo",  {31'h0, tmo_err}, 32'h0);
        rst_n = 1'b1;
        step(2);

        // ---- 1: 14-byte single pass ----
        for (int i = 0; i < 14; i++) write_tbl(i, t1[i]);
        for (int i = 0; i < 14; i++) exp_q.push_back(t1[i]);
        tx_busy = 10;
        acc0 = acc_cnt;
        d0 = done_cnt;
        t0 = cyc;
        do_start(14, 0, 1);
        wait_vld(20, "t1_first_vld");
        check("t1_start_latency", cyc - t0, 2);
        wait_done(1000, "t1_done");
        check("t1_abort", {31'h0, abort}, 32'h0);
        check("t1_pass_cnt", {16'h0, pass_cnt}, 32'd1);
        check("t1_idx_wrap", {26'h0, byte_idx}, 32'd0);
        step(4);
        check("t1_bytes", acc_cnt - acc0, 14);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_queue_empty", exp_q.size(), 0);

        // ---- 2: gap 100, two passes, 50-cycle tx ----
        write_tbl(0, 8'h11);
        write_tbl(1, 8'h22);
        write_tbl(2, 8'h33);
        for (int p = 0; p < 2; p++) begin
            exp_q.push_back(8'h11);
            exp_q.push_back(8'h22);
            exp_q.push_back(8'h33);
        end
        tx_busy = 50;
        base = acc_cnt;
        do_start(3, 100, 2);
        wait_done(3000, "t2_done");
        check("t2_bytes", acc_cnt - base, 6);
        check("t2_pass_cnt", {16'h0, pass_cnt}, 32'd2);
        check("t2_abort", {31'h0, abort}, 32'h0);
        for (int i = 1; i < 6; i++)
            check("t2_rise_to_vld", acc_cyc[(base + i) & 255] - rise_cyc[(base + i - 1) & 255], 102);
        step(2);

        // ---- 3: len 0 ----
        v0 = vld_hi_cnt;
        d0 = done_cnt;
        b0 = busy_cnt;
        t0 = cyc;
        do_start(0, 0, 1);
        wait_done(10, "t3_done");
        check("t3_done_latency", cyc - t0, 2);
        step(3);
        check("t3_no_vld", vld_hi_cnt - v0, 0);
        check("t3_busy_cycles", busy_cnt - b0, 1);
        check("t3_done_once", done_cnt - d0, 1);

        // ---- 4: endless, stop during WAIT_TX ----
        for (int i = 0; i < 12; i++) exp_q.push_back((i % 3 == 0) ? 8'h11 : (i % 3 == 1) ? 8'h22 : 8'h33);
        tx_busy = 20;
        base = acc_cnt;
        do_start(3, 0, 0);
        t0 = 0;
        while (acc_cnt < base + 5 && t0 < 2000) begin
            step(1);
            t0++;
        end
        check("t4_reach_byte5", acc_cnt - base, 5);
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        acc0 = acc_cnt;
        v0 = vld_hi_cnt;
        d0 = done_cnt;
        t0 = 0;
        while (!rdy && t0 < 100) begin
            step(1);
            t0++;
        end
        r0 = cyc;
        check("t4_busy_while_shifting", {31'h0, busy}, 32'h1);
        check("t4_no_done_while_shifting", done_cnt - d0, 0);
        wait_done(20, "t4_done");
        check("t4_done_after_byte", cyc - r0, 2);
        check("t4_abort", {31'h0, abort}, 32'h1);
        check("t4_pass_cnt", {16'h0, pass_cnt}, 32'd1);
        check("t4_byte_idx", {26'h0, byte_idx}, 32'd1);
        step(3);
        check("t4_no_more_bytes", acc_cnt - acc0, 0);
        check("t4_no_more_vld", vld_hi_cnt - v0, 0);
        exp_q.delete();

        // ---- 5: timeout ----
        tx_hold = 1'b1;
        v0 = vld_hi_cnt;
        do_start(3, 0, 1);
        wait_done(60, "t5_done");
        check("t5_vld_cycles", vld_hi_cnt - v0, 16);
        check("t5_tmo_err", {31'h0, tmo_err}, 32'h1);
        check("t5_abort", {31'h0, abort}, 32'h1);
        step(5);
        check("t5_tmo_sticky", {31'h0, tmo_err}, 32'h1);
        // start together with stop in IDLE is ignored
        d0 = done_cnt;
        stop = 1'b1;
        do_start(3, 0, 1);
        stop = 1'b0;
        step(3);
        check("stopstart_busy", {31'h0, busy}, 32'h0);
        check("stopstart_no_done", done_cnt - d0, 0);
        check("stopstart_tmo_kept", {31'h0, tmo_err}, 32'h1);
        do_start(0, 0, 1);
        check("t5_tmo_cleared", {31'h0, tmo_err}, 32'h0);
        wait_done(10, "t5_len0_done");
        tx_hold = 1'b0;
        step(2);

        // ---- 6: async reset during SEND ----
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 3 == 0) ? 8'h11 : (i % 3 == 1) ? 8'h22 : 8'h33);
        tx_busy = 4;
        base = acc_cnt;
        do_start(3, 0, 2);
        t0 = 0;
        while (acc_cnt < base + 4 && t0 < 500) begin
            step(1);
            t0++;
        end
        tx_hold = 1'b1;
        check("t6_reach_byte4", acc_cnt - base, 4);
        step(1);
        wait_vld(30, "t6_stuck_vld");
        check("t6_idx_before", {26'h0, byte_idx}, 32'd1);
        check("t6_pass_before", {16'h0, pass_cnt}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", {31'h0, vld}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        check("t6_rst_idx", {26'h0, byte_idx}, 32'd0);
        check("t6_rst_pass", {16'h0, pass_cnt}, 32'd0);
        step(2);
        rst_n = 1'b1;
        exp_q.delete();
        tx_hold = 1'b0;
        step(2);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        base = acc_cnt;
        do_start(3, 0, 1);
        wait_done(200, "t6_replay_done");
        check("t6_replay_bytes", acc_cnt - base, 3);
        check("t6_replay_abort", {31'h0, abort}, 32'h0);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
